hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage WISC-SP13 core. Sits beside the decode stage and tracks the destination registers of instructions in flight in EX and MEM. Holds the decode instruction (stall) and injects a bubble into EX when a source register is not yet readable. Also freezes the whole pipeline on a memory-busy condition, and counts stall cycles for performance debug. Register-file write-before-read bypass covers the WB stage, so WB is never a stall source.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_tag_stage.sv | 48 ++++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, tag type and stage indices for the hazard controller
package hazard_pkg;

  localparam int NREG_BITS = 3;
  localparam int CNT_W     = 16;

  // Stage slots in the tag pipeline
  localparam int EX  = 0;
  localparam int MEM = 1;

  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] rd;
    logic                 is_load;
  } tag_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode-side hazard interface: decode/pipeline inputs and control outputs
interface hazard_ctrl_if #(
  parameter int NREG_BITS = hazard_pkg::NREG_BITS,
  parameter int CNT_W     = hazard_pkg::CNT_W
);

  logic                 id_valid;
  logic [NREG_BITS-1:0] id_rs_sel;
  logic                 id_rs_used;
  logic [NREG_BITS-1:0] id_rt_sel;
  logic                 id_rt_used;
  logic [NREG_BITS-1:0] id_rd_sel;
  logic                 id_reg_write;
  logic                 id_is_load;
  logic                 flush;
  logic                 mem_busy;
  logic                 stall;
  logic                 ex_bubble;
  logic                 freeze;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
    output id_rd_sel, id_reg_write, id_is_load, flush, mem_busy,
    input  stall, ex_bubble, freeze, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
    input  id_rd_sel, id_reg_write, id_is_load, flush, mem_busy,
    output stall, ex_bubble, freeze, stall_cnt
  );

endinterface

// File: rtl/hazard_tag_stage.sv
// rtl/hazard_tag_stage.sv - one destination-tag register with hold/clear/load and a two-source match
module hazard_tag_stage
  import hazard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 clear,
  input  logic                 load,
  input  tag_t                 tag_in,
  input  logic [NREG_BITS-1:0] rs_sel,
  input  logic                 rs_used,
  input  logic [NREG_BITS-1:0] rt_sel,
  input  logic                 rt_used,
  output tag_t                 tag_q,
  output logic                 hit
);

  tag_t tag_d;

  // Next tag: hold wins, then clear (insert an empty slot), then load
  always_comb begin
    tag_d = tag_q;
    if (!hold) begin
      if (clear) begin
        tag_d = '0;
      end else if (load) begin
        tag_d = tag_in;
      end
    end
  end

  // Tag register, emptied asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // A live entry matches when either used source names its destination
  always_comb begin
    hit = tag_q.valid & ((rs_used & (rs_sel == tag_q.rd)) |
                         (rt_used & (rt_sel == tag_q.rd)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage stall/bubble/freeze control; HAZARD_FWD_EN selects load-use-only interlock
module hazard_ctrl #(
  parameter int NREG_BITS = hazard_pkg::NREG_BITS,
  parameter int CNT_W     = hazard_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);
  import hazard_pkg::*;

  logic [NREG_BITS-1:0] rs_sel;
  logic [NREG_BITS-1:0] rt_sel;
  logic [NREG_BITS-1:0] rd_sel;
  tag_t                 stage_tag [2];
  logic                 stage_hit [2];
  tag_t                 id_tag;
  logic                 id_live;
  logic                 stall_raw;
  logic                 ex_clear;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_d;

  assign rs_sel = hif.id_rs_sel;
  assign rt_sel = hif.id_rt_sel;
  assign rd_sel = hif.id_rd_sel;

  // A flushed decode slot is dead and cannot raise a hazard
  assign id_live = hif.id_valid & ~hif.flush;

  // What decode would place into EX if it issues this cycle
  always_comb begin
    id_tag         = '0;
    id_tag.valid   = hif.id_valid & hif.id_reg_write;
    id_tag.rd      = rd_sel;
    id_tag.is_load = hif.id_is_load;
  end

`ifdef HAZARD_FWD_EN
  // Forwarding covers everything except a load result needed immediately
  assign stall_raw = id_live & stage_hit[EX] & stage_tag[EX].is_load;

  logic unused_mem;
  assign unused_mem = ^{stage_tag[MEM], stage_hit[MEM]};
`else
  // Full interlock: wait until the producer has left MEM
  assign stall_raw = id_live & (stage_hit[EX] | stage_hit[MEM]);

  logic unused_mem;
  assign unused_mem = ^stage_tag[MEM];
`endif

  // A bubble enters EX whenever decode does not issue into it
  assign ex_clear = hif.flush | stall_raw;

  hazard_tag_stage u_ex_tag (
    .clk     (clk),
    .rst     (rst),
    .hold    (hif.mem_busy),
    .clear   (ex_clear),
    .load    (1'b1),
    .tag_in  (id_tag),
    .rs_sel  (rs_sel),
    .rs_used (hif.id_rs_used),
    .rt_sel  (rt_sel),
    .rt_used (hif.id_rt_used),
    .tag_q   (stage_tag[EX]),
    .hit     (stage_hit[EX])
  );

  hazard_tag_stage u_mem_tag (
    .clk     (clk),
    .rst     (rst),
    .hold    (hif.mem_busy),
    .clear   (1'b0),
    .load    (1'b1),
    .tag_in  (stage_tag[EX]),
    .rs_sel  (rs_sel),
    .rs_used (hif.id_rs_used),
    .rt_sel  (rt_sel),
    .rt_used (hif.id_rt_used),
    .tag_q   (stage_tag[MEM]),
    .hit     (stage_hit[MEM])
  );

  // Control outputs, priority freeze > flush > raw hazard > normal
  always_comb begin
    hif.freeze    = hif.mem_busy;
    hif.stall     = hif.mem_busy | stall_raw;
    hif.ex_bubble = ~hif.mem_busy & ex_clear;
  end

  // Stall-cycle counter, sticks at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hif.stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if #(.NREG_BITS(3), .CNT_W(16)) hif ();

  hazard_ctrl #(.NREG_BITS(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HAZARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                       input logic rw, input logic ld);
    hif.id_valid     = v;
    hif.id_rs_sel    = rs;
    hif.id_rs_used   = rsu;
    hif.id_rt_sel    = rt;
    hif.id_rt_used   = rtu;
    hif.id_rd_sel    = rd;
    hif.id_reg_write = rw;
    hif.id_is_load   = ld;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    hif.flush    = 1'b0;
    hif.mem_busy = 1'b0;
  endtask

  // Checks the outputs for the inputs currently driven, then advances one clock
  task automatic expect_cycle(input string tag, input logic s, input logic b, input logic f);
    @(negedge clk);
    check_eq({tag, ".stall"}, {31'd0, hif.stall}, {31'd0, s});
    check_eq({tag, ".bubble"}, {31'd0, hif.ex_bubble}, {31'd0, b});
    check_eq({tag, ".freeze"}, {31'd0, hif.freeze}, {31'd0, f});
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check_eq(tag, {16'd0, hif.stall_cnt}, {16'd0, exp});
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Producer writes r3, gap unrelated instructions, consumer reads r3 and r1
  task automatic run_pair(input string tag, input logic ld, input int gap, input int exp_stalls);
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, ld);
    expect_cycle({tag, ".prod"}, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < gap; g++) begin
      drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0);
      expect_cycle({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    for (int k = 0; k < exp_stalls; k++) begin
      expect_cycle({tag, ".stall"}, 1'b1, 1'b1, 1'b0);
    end
    expect_cycle({tag, ".issue"}, 1'b0, 1'b0, 1'b0);
    idle();
    check_cnt({tag, ".cnt"}, 16'(exp_stalls));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst.stall", {31'd0, hif.stall}, 32'd0);
    check_eq("rst.bubble", {31'd0, hif.ex_bubble}, 32'd0);
    check_eq("rst.freeze", {31'd0, hif.freeze}, 32'd0);
    check_eq("rst.cnt", {16'd0, hif.stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) expect_cycle("idle", 1'b0, 1'b0, 1'b0);
    check_cnt("idle.cnt", 16'd0);

    // Dependent pairs at several distances, ALU and load producers
    run_pair("alu_b2b", 1'b0, 0, (FWD != 0) ? 0 : 2);
    run_pair("ld_b2b",  1'b1, 0, (FWD != 0) ? 1 : 2);
    run_pair("ld_gap1", 1'b1, 1, (FWD != 0) ? 0 : 1);
    run_pair("ld_gap2", 1'b1, 2, 0);

    // Freeze during a pending load hazard on r3
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1);
    expect_cycle("frz.prod", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    hif.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle("frz.hold", 1'b1, 1'b0, 1'b1);
    hif.mem_busy = 1'b0;
    for (int i = 0; i < ((FWD != 0) ? 1 : 2); i++) expect_cycle("frz.stall", 1'b1, 1'b1, 1'b0);
    expect_cycle("frz.issue", 1'b0, 1'b0, 1'b0);
    idle();
    check_cnt("frz.cnt", (FWD != 0) ? 16'd4 : 16'd5);

    // Flush kills a dependent consumer; its destination never becomes a hazard
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1);
    expect_cycle("fl.prod", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 1'b0);
    hif.flush = 1'b1;
    expect_cycle("fl.kill", 1'b0, 1'b1, 1'b0);
    hif.flush = 1'b0;
    drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0);
    expect_cycle("fl.next", 1'b0, 1'b0, 1'b0);
    idle();
    check_cnt("fl.cnt", 16'd0);

    // Reset asserted mid-stall
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1);
    expect_cycle("mr.prod", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("mr.pre", {31'd0, hif.stall}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mr.stall", {31'd0, hif.stall}, 32'd0);
    check_eq("mr.bubble", {31'd0, hif.ex_bubble}, 32'd0);
    hif.mem_busy = 1'b1;
    #1;
    check_eq("mr.busy_stall", {31'd0, hif.stall}, 32'd1);
    check_eq("mr.busy_freeze", {31'd0, hif.freeze}, 32'd1);
    check_eq("mr.cnt", {16'd0, hif.stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;

    // Counter saturation
    do_reset();
    hif.mem_busy = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check_cnt("sat.fffe", 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check_cnt("sat.ffff", 16'hFFFF);
    @(posedge clk);
    #1;
    check_cnt("sat.hold", 16'hFFFF);
    hif.mem_busy = 1'b0;
    expect_cycle("sat.idle", 1'b0, 1'b0, 1'b0);
    check_cnt("sat.keep", 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
